// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - instruction fetch/decode/execute sequencer with CU watchdog
//
// Purpose:
//   Fetches 16-bit instruction words from a 1-cycle synchronous ROM, decodes
//   them, presents opcode/dest/src to a control unit (CU), and waits for the
//   CU to report completion (cu_state == 3'b111). If the CU stalls, a watchdog
//   abandons the instruction after TIMEOUT execute cycles and sets a sticky
//   error flag. Opcode 4'b1111 halts; 4'b0000, 4'b1101 and 4'b1110 are NOPs
//   that retire without involving the CU.
//
// Parameters:
//   RESET_PC  - program counter value after reset and on restart from HALT
//   TIMEOUT   - execute cycles allowed before the CU is considered hung
//
// Ports:
//   clk              in   clock, all state updates on the rising edge
//   rst              in   asynchronous active-high reset
//   start            in   level; leaves IDLE, or restarts from HALT
//   rom_address      out  instruction fetch address (the PC)
//   rom_read_enable  out  ROM read strobe, one cycle per fetch
//   rom_data         in   instruction word, valid the cycle after the strobe
//   opcode           out  opcode to CU, zero outside EXEC
//   dest             out  destination field to CU, zero outside EXEC
//   src              out  source field / immediate to CU, zero outside EXEC
//   cu_state         in   CU progress, 3'b111 = instruction complete
//   busy             out  high in every state except IDLE and HALT
//   halted           out  high in HALT
//   err              out  sticky CU-timeout flag
//   retired          out  saturating count of completed instructions

module instr_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_address,
    output logic        rom_read_enable,
    input  logic [15:0] rom_data,
    output logic [3:0]  opcode,
    output logic [5:0]  dest,
    output logic [5:0]  src,
    input  logic [2:0]  cu_state,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [15:0] retired
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_CLEAR  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      pc;
    logic [15:0]     ir;
    logic [WD_W-1:0] watchdog;

    logic [3:0]  ir_opcode;
    logic        ir_halt;
    logic        ir_nop;
    logic        cu_done;
    logic        wd_expired;
    logic [15:0] retired_inc;

    assign ir_opcode   = ir[15:12];
    assign ir_halt     = (ir_opcode == 4'b1111);
    assign ir_nop      = (ir_opcode == 4'b0000) || (ir_opcode == 4'b1101) ||
                         (ir_opcode == 4'b1110);
    assign cu_done     = (cu_state == 3'b111);
    assign wd_expired  = (watchdog == WD_LAST);
    // Retired count sticks at all-ones rather than wrapping.
    assign retired_inc = (retired == 16'hFFFF) ? retired : retired + 16'd1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_FETCH;
            S_FETCH:  state_next = S_WAIT;
            S_WAIT:   state_next = S_DECODE;
            S_DECODE: begin
                if (ir_halt) begin
                    state_next = S_HALT;
                end else if (ir_nop) begin
                    state_next = S_FETCH;
                end else begin
                    state_next = S_EXEC;
                end
            end
            // Completion and timeout both leave EXEC; the datapath decides
            // which one is recorded.
            S_EXEC:   if (cu_done || wd_expired) state_next = S_CLEAR;
            S_CLEAR:  state_next = S_FETCH;
            S_HALT:   if (start) state_next = S_FETCH;
            default:  state_next = S_IDLE;
        endcase
    end

    // Datapath: PC, instruction register, watchdog, error and retire count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            ir       <= 16'h0000;
            watchdog <= '0;
            err      <= 1'b0;
            retired  <= 16'h0000;
        end else begin
            case (state)
                S_WAIT: begin
                    ir <= rom_data;
                end
                S_DECODE: begin
                    if (!ir_halt) begin
                        if (ir_nop) begin
                            pc      <= pc + 8'd1;
                            retired <= retired_inc;
                        end else begin
                            watchdog <= '0;
                        end
                    end
                end
                S_EXEC: begin
                    // Completion takes priority over a coincident timeout.
                    if (cu_done) begin
                        pc      <= pc + 8'd1;
                        retired <= retired_inc;
                    end else if (wd_expired) begin
                        pc  <= pc + 8'd1;
                        err <= 1'b1;
                    end else begin
                        watchdog <= watchdog + WD_W'(1);
                    end
                end
                S_HALT: begin
                    if (start) pc <= RESET_PC;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode straight from the state register so that an
    // asynchronous reset silences the CU interface in the same cycle.
    always_comb begin
        rom_address     = pc;
        rom_read_enable = 1'b0;
        opcode          = 4'b0000;
        dest            = 6'd0;
        src             = 6'd0;
        busy            = 1'b1;
        halted          = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_FETCH: begin
                rom_read_enable = 1'b1;
            end
            S_EXEC: begin
                opcode = ir[15:12];
                dest   = ir[11:6];
                src    = ir[5:0];
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer

module tb_instr_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        start2;
    logic [15:0] rom_data;
    logic [15:0] rom_data2;
    logic [2:0]  cu_state;
    logic [2:0]  cu_state2;

    logic [7:0]  rom_address,  rom_address2;
    logic        rom_read_enable, rom_read_enable2;
    logic [3:0]  opcode, opcode2;
    logic [5:0]  dest, dest2, src, src2;
    logic        busy, busy2, halted, halted2, err, err2;
    logic [15:0] retired, retired2;

    logic [15:0] rom [0:255];

    int nt = 0;
    int nf = 0;
    int exec_cnt;
    int exec_cycles;
    int done_at;
    int double_strobe;
    int fetch_log[$];
    int fetch_log2[$];
    logic [3:0] last_op;
    logic [5:0] last_dest;
    logic [5:0] last_src;

    instr_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start),
        .rom_address(rom_address), .rom_read_enable(rom_read_enable),
        .rom_data(rom_data), .opcode(opcode), .dest(dest), .src(src),
        .cu_state(cu_state), .busy(busy), .halted(halted), .err(err),
        .retired(retired)
    );

    instr_sequencer #(.RESET_PC(8'hFF), .TIMEOUT(15)) u_dut_ff (
        .clk(clk), .rst(rst), .start(start2),
        .rom_address(rom_address2), .rom_read_enable(rom_read_enable2),
        .rom_data(rom_data2), .opcode(opcode2), .dest(dest2), .src(src2),
        .cu_state(cu_state2), .busy(busy2), .halted(halted2), .err(err2),
        .retired(retired2)
    );

    // One clock: ROM answers the previous cycle's strobe, CU model reacts to
    // the EXEC cycle count (reports 3'b111 from EXEC cycle done_at onward).
    task automatic tick();
        logic       re1, re2;
        logic [7:0] a1, a2;
        re1 = rom_read_enable;
        a1  = rom_address;
        re2 = rom_read_enable2;
        a2  = rom_address2;
        @(posedge clk);
        #1;
        if (re1) begin
            rom_data = rom[a1];
            fetch_log.push_back(int'(a1));
        end
        if (re2) begin
            rom_data2 = rom[a2];
            fetch_log2.push_back(int'(a2));
        end
        if (re1 && rom_read_enable) double_strobe++;
        if (opcode != 4'b0000) begin
            exec_cnt++;
            exec_cycles++;
            last_op   = opcode;
            last_dest = dest;
            last_src  = src;
        end else begin
            exec_cnt = 0;
        end
        cu_state = (done_at != 0 && exec_cnt >= done_at) ? 3'b111 : 3'b000;
    endtask

    task automatic clear_obs();
        fetch_log.delete();
        fetch_log2.delete();
        exec_cnt      = 0;
        exec_cycles   = 0;
        double_strobe = 0;
        last_op       = 4'h0;
        last_dest     = 6'h0;
        last_src      = 6'h0;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        rom_data  = 16'h0;
        rom_data2 = 16'h0;
        cu_state  = 3'b000;
        done_at   = 0;
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
        clear_obs();
    endtask

    task automatic run1(output int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!halted && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic run2(output int n);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 1;
        while (!halted2 && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        start2 = 1'b0;
        rom_data = 16'h0; rom_data2 = 16'h0;
        cu_state = 3'b000; cu_state2 = 3'b000;
        done_at = 0;
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
        clear_obs();
        @(posedge clk);
        #1;
        nt++; if (busy !== 1'b0) begin nf++; $display("FAIL reset_busy: got %b expected 0", busy); end
        nt++; if (halted !== 1'b0) begin nf++; $display("FAIL reset_halted: got %b expected 0", halted); end
        nt++; if (err !== 1'b0) begin nf++; $display("FAIL reset_err: got %b expected 0", err); end
        nt++; if (retired !== 16'h0) begin nf++; $display("FAIL reset_retired: got %h expected 0000", retired); end
        nt++; if ({opcode, dest, src} !== 16'h0) begin nf++; $display("FAIL reset_cu_fields: got %h expected 0000", {opcode, dest, src}); end
        nt++; if (rom_read_enable !== 1'b0) begin nf++; $display("FAIL reset_rom_re: got %b expected 0", rom_read_enable); end
        nt++; if (rom_address !== 8'h00) begin nf++; $display("FAIL reset_pc: got %h expected 00", rom_address); end
        nt++; if (rom_address2 !== 8'hFF) begin nf++; $display("FAIL reset_pc_ff: got %h expected ff", rom_address2); end
        rst = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        nt++; if (busy !== 1'b0 || rom_read_enable !== 1'b0) begin nf++; $display("FAIL idle_hold: busy %b re %b expected 0 0", busy, rom_read_enable); end
    endtask

    task automatic test_mvi();
        int n;
        do_reset();
        rom[0] = 16'hC0C5;
        rom[1] = 16'hF000;
        done_at = 2;
        run1(n);
        nt++; if (n != 10) begin nf++; $display("FAIL mvi_cycles: got %0d expected 10", n); end
        nt++; if (exec_cycles != 2) begin nf++; $display("FAIL mvi_exec_cycles: got %0d expected 2", exec_cycles); end
        nt++; if (last_op !== 4'hC || last_dest !== 6'd3 || last_src !== 6'd5) begin nf++; $display("FAIL mvi_fields: got op %h dest %0d src %0d expected c 3 5", last_op, last_dest, last_src); end
        nt++; if (retired !== 16'd1) begin nf++; $display("FAIL mvi_retired: got %0d expected 1", retired); end
        nt++; if (halted !== 1'b1 || busy !== 1'b0) begin nf++; $display("FAIL mvi_halted: halted %b busy %b expected 1 0", halted, busy); end
        nt++; if (rom_address !== 8'h01) begin nf++; $display("FAIL mvi_pc: got %h expected 01", rom_address); end
        nt++; if (err !== 1'b0) begin nf++; $display("FAIL mvi_err: got %b expected 0", err); end
        nt++; if (double_strobe != 0) begin nf++; $display("FAIL mvi_strobe_width: got %0d long strobes expected 0", double_strobe); end
    endtask

    task automatic test_nop();
        int n;
        do_reset();
        rom[0] = 16'h0000;
        rom[1] = 16'h0000;
        rom[2] = 16'h0000;
        rom[3] = 16'hF000;
        run1(n);
        nt++; if (n != 13) begin nf++; $display("FAIL nop_cycles: got %0d expected 13", n); end
        nt++; if (exec_cycles != 0) begin nf++; $display("FAIL nop_opcode_quiet: got %0d nonzero cycles expected 0", exec_cycles); end
        nt++; if (retired !== 16'd3) begin nf++; $display("FAIL nop_retired: got %0d expected 3", retired); end
        nt++; if (halted !== 1'b1 || rom_address !== 8'h03) begin nf++; $display("FAIL nop_halt_pc: halted %b pc %h expected 1 03", halted, rom_address); end
        nt++; if (fetch_log.size() != 4 || fetch_log[0] != 0 || fetch_log[3] != 3) begin nf++; $display("FAIL nop_fetch_order: got %0d fetches expected 4 from 0 to 3", fetch_log.size()); end
    endtask

    task automatic test_halt_restart();
        int n;
        clear_obs();
        run1(n);
        nt++; if (n != 13) begin nf++; $display("FAIL restart_cycles: got %0d expected 13", n); end
        nt++; if (retired !== 16'd6) begin nf++; $display("FAIL restart_retired: got %0d expected 6", retired); end
        nt++; if (fetch_log.size() == 0 || fetch_log[0] != 0) begin nf++; $display("FAIL restart_first_fetch: got %0d fetches expected first at 0", fetch_log.size()); end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        rom[0] = 16'h2041;
        rom[1] = 16'hF000;
        done_at = 0;
        run1(n);
        nt++; if (n != 23) begin nf++; $display("FAIL timeout_cycles: got %0d expected 23", n); end
        nt++; if (exec_cycles != 15) begin nf++; $display("FAIL timeout_exec_cycles: got %0d expected 15", exec_cycles); end
        nt++; if (last_op !== 4'h2 || last_dest !== 6'd1 || last_src !== 6'd1) begin nf++; $display("FAIL timeout_fields: got op %h dest %0d src %0d expected 2 1 1", last_op, last_dest, last_src); end
        nt++; if (err !== 1'b1) begin nf++; $display("FAIL timeout_err: got %b expected 1", err); end
        nt++; if (retired !== 16'd0) begin nf++; $display("FAIL timeout_retired: got %0d expected 0", retired); end
        nt++; if (fetch_log.size() != 2 || fetch_log[1] != 1) begin nf++; $display("FAIL timeout_next_fetch: got %0d fetches expected 2 ending at 1", fetch_log.size()); end
    endtask

    task automatic test_reset_after_state();
        rst = 1'b1;
        #1;
        nt++; if (err !== 1'b0 || retired !== 16'd0) begin nf++; $display("FAIL async_reset_state: err %b retired %0d expected 0 0", err, retired); end
        nt++; if (halted !== 1'b0 || busy !== 1'b0 || rom_address !== 8'h00) begin nf++; $display("FAIL async_reset_fsm: halted %b busy %b pc %h expected 0 0 00", halted, busy, rom_address); end
        do_reset();
    endtask

    task automatic test_tie();
        int n;
        do_reset();
        rom[0] = 16'h2041;
        rom[1] = 16'hF000;
        done_at = 15;
        run1(n);
        nt++; if (n != 23 || exec_cycles != 15) begin nf++; $display("FAIL tie_timing: got %0d cycles %0d exec expected 23 15", n, exec_cycles); end
        nt++; if (err !== 1'b0 || retired !== 16'd1) begin nf++; $display("FAIL tie_completion_wins: err %b retired %0d expected 0 1", err, retired); end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        rom[8'hFF] = 16'h0000;
        rom[8'h00] = 16'hF000;
        run2(n);
        nt++; if (n != 7) begin nf++; $display("FAIL wrap_cycles: got %0d expected 7", n); end
        nt++; if (fetch_log2.size() != 2 || fetch_log2[0] != 255 || fetch_log2[1] != 0) begin nf++; $display("FAIL wrap_fetch_order: got %0d fetches expected ff then 00", fetch_log2.size()); end
        nt++; if (halted2 !== 1'b1 || rom_address2 !== 8'h00 || retired2 !== 16'd1) begin nf++; $display("FAIL wrap_final: halted %b pc %h retired %0d expected 1 00 1", halted2, rom_address2, retired2); end
        nt++; if ({opcode2, dest2, src2} !== 16'h0 || busy2 !== 1'b0 || err2 !== 1'b0) begin nf++; $display("FAIL wrap_quiet: fields %h busy %b err %b expected 0000 0 0", {opcode2, dest2, src2}, busy2, err2); end
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        rom[0] = 16'h2041;
        done_at = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        nt++; if (opcode !== 4'h2 || exec_cycles != 3) begin nf++; $display("FAIL midexec_pre: opcode %h exec %0d expected 2 3", opcode, exec_cycles); end
        #2;
        rst = 1'b1;
        #1;
        nt++; if (opcode !== 4'h0 || dest !== 6'd0 || src !== 6'd0) begin nf++; $display("FAIL midexec_opcode_drop: got op %h dest %0d src %0d expected 0 0 0", opcode, dest, src); end
        nt++; if (busy !== 1'b0 || rom_address !== 8'h00 || retired !== 16'd0) begin nf++; $display("FAIL midexec_state: busy %b pc %h retired %0d expected 0 00 0", busy, rom_address, retired); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cu_state = 3'b000;
        clear_obs();
        start = 1'b1;
        tick();
        start = 1'b0;
        nt++; if (rom_read_enable !== 1'b1 || rom_address !== 8'h00) begin nf++; $display("FAIL midexec_refetch: re %b addr %h expected 1 00", rom_read_enable, rom_address); end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mvi();
        test_nop();
        test_halt_restart();
        test_timeout();
        test_reset_after_state();
        test_tie();
        test_wrap();
        test_reset_mid_exec();
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter RESET_PC, default 8'h00, PC value loaded on reset and on restart from HALT.
REQ-002 Parameter TIMEOUT, default 15, maximum EXEC cycles to wait for CU completion.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  level; begins fetching from IDLE, restarts from HALT.
REQ-006 rom_address  out  8  instruction fetch address (PC).
REQ-007 rom_read_enable  out  1  ROM read strobe.
REQ-008 rom_data  in  16  instruction word; valid the cycle after the strobe (1-cycle synchronous ROM).
REQ-009 opcode  out  4  opcode to CU; 4'b0000 whenever not in EXEC.
REQ-010 dest  out  6  dest field to CU; 0 when not in EXEC.
REQ-011 src  out  6  src field / immediate to CU; 0 when not in EXEC.
REQ-012 cu_state  in  3  CU progress; 3'b111 means instruction complete.
REQ-013 busy  out  1  high in every state except IDLE and HALT.
REQ-014 halted  out  1  high in HALT.
REQ-015 err  out  1  sticky CU-timeout flag.
REQ-016 retired  out  16  count of completed instructions.

Function
REQ-017 Instruction word shall decode as opcode=[15:12], dest=[11:6], src=[5:0].
REQ-018 States: IDLE, FETCH, WAIT, DECODE, EXEC, CLEAR, HALT.
REQ-019 IDLE: outputs quiet; start=1 -> FETCH next cycle.
REQ-020 FETCH: rom_read_enable=1, rom_address=pc for exactly one cycle -> WAIT.
REQ-021 WAIT: IR <= rom_data -> DECODE; rom_read_enable=0.
REQ-022 DECODE: IR opcode 4'b1111 -> HALT, pc unchanged; 4'b0000, 4'b1101 or 4'b1110 -> NOP: pc+1, retired+1, -> FETCH; otherwise watchdog <= 0, -> EXEC.
REQ-023 EXEC: drive opcode/dest/src from IR; cu_state==3'b111 -> CLEAR, pc+1, retired+1.
REQ-024 EXEC: cu_state!=3'b111 with watchdog==TIMEOUT-1 -> CLEAR, pc+1, err<=1, retired unchanged; otherwise watchdog+1.
REQ-025 cu_state==3'b111 and timeout in the same cycle: completion wins, err unchanged.
REQ-026 CLEAR: opcode=4'b0000 for exactly one cycle (forces CU back to state 3'b000) -> FETCH.
REQ-027 HALT: holds; start=1 -> pc<=RESET_PC, -> FETCH; err and retired preserved.
REQ-028 pc is 8-bit, wraps 8'hFF -> 8'h00 with no flag.
REQ-029 retired saturates at 16'hFFFF.
REQ-030 Instruction latency (non-NOP): FETCH+WAIT+DECODE+EXEC(n)+CLEAR = n+4 cycles; NOP = 3 cycles; CU sees a new opcode no earlier than 3 cycles after any CLEAR.
REQ-031 start is ignored outside IDLE and HALT.

Reset
REQ-032 rst=1 shall immediately force IDLE, pc=RESET_PC, IR=0, watchdog=0, opcode/dest/src=0, rom_read_enable=0, busy=0, halted=0, err=0, retired=0.
REQ-033 rst asserted mid-EXEC shall drop opcode to 4'b0000 asynchronously; no pc increment or retire for the aborted instruction.
REQ-034 After rst deasserts, the block stays in IDLE until start=1.

Verification
REQ-035 Reset: rst pulse with random prior state -> all outputs at REQ-032 values, opcode=0, busy=0.
REQ-036 ROM[0]=16'hC0C5 (MVI dest=3, #5), ROM[1]=16'hF000; CU model returns 3'b111 one cycle after EXEC entry -> dest=3/src=5 shown in EXEC, retired=1, halted=1, pc=1.
REQ-037 ROM[0..2]=16'h0000, ROM[3]=16'hF000 -> three NOPs at 3 cycles each, opcode never nonzero, retired=3, halt at pc=3.
REQ-038 ROM[0]=16'h2041, CU model never reaches 3'b111 -> exactly TIMEOUT EXEC cycles, one CLEAR cycle, err=1, retired=0, next fetch at address 1.
REQ-039 RESET_PC=8'hFF, ROM[FF]=NOP, ROM[00]=16'hF000 -> fetch at FF then 00, halted=1, pc=0.
REQ-040 rst asserted during third EXEC cycle -> same-cycle opcode=0, busy=0, pc=RESET_PC; start afterwards refetches from RESET_PC.
